pc_sequencer: RTL
=================

# pc_sequencer

Next-PC controller for the RV32I fetch front end. Owns the program counter, drives the instruction-fetch request handshake, and sequences the shared 32-bit PC+immediate target adder to resolve taken branches, JAL and JALR. Sits between instruction memory and the decode/branch-compare stage. The target adder is instantiated outside this block and reached through the `adder_*` ports.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  out  1  fetch request valid.
- `fetch_addr`  out  32  fetch address; equals current PC.
- `fetch_ready`  in  1  instruction memory accepts the request.
- `dec_valid`  in  1  decode presents a control-flow descriptor.
- `dec_ready`  out  1  sequencer can accept a descriptor.
- `br_type`  in  2  descriptor kind: 00 = none, 01 = conditional branch, 10 = JAL, 11 = JALR.
- `br_taken`  in  1  branch outcome; used only when `br_type` = 01.
- `br_imm`  in  32  sign-extended immediate.
- `dec_pc`  in  32  PC of the instruction being resolved.
- `rs1_val`  in  32  rs1 operand, used for JALR.
- `adder_a`  out  32  shared adder operand A.
- `adder_b`  out  32  shared adder operand B.
- `adder_sum`  in  32  shared adder result, combinational (a+b mod 2^32).
- `redirect`  out  1  one-cycle pulse: PC was replaced by a target; downstream flushes.
- `trap`  out  1  sticky misaligned-target trap.
- `trap_addr`  out  32  offending target address.

## Operation
- **Reset values** (asynchronous): `pc` = RESET_PC, state = BOOT, and every output is 0. `fetch_addr` still reflects `pc` = RESET_PC.
- **BOOT**: lasts one cycle, then goes to FETCH. This keeps `fetch_valid` low for the first clock after reset release.
- **FETCH**: `fetch_valid` = 1 and `dec_ready` = 1.
  - If `fetch_valid && fetch_ready`: `pc` <= `pc` + 4, using the local incrementer (not the shared adder). Addition wraps mod 2^32.
  - A descriptor is accepted when `dec_valid && dec_ready`. It requests a redirect if `br_type` = 10, `br_type` = 11, or (`br_type` = 01 and `br_taken`). An accepted redirect registers the adder operands and moves the state to CALC. Other descriptors are consumed with no effect.
  - Operand registers: A = `rs1_val` for JALR, otherwise `dec_pc`. B = `br_imm`.
- **CALC** (one cycle):
  - `fetch_valid` = 0 and `dec_ready` = 0.
  - `adder_a` and `adder_b` drive the registered operands.
  - Target = `adder_sum`, with bit 0 forced to 0 for JALR.
  - If target[1:0] != 0: go to TRAP and capture `trap_addr` = target.
  - Otherwise: `pc` <= target and go to FETCH, with `redirect` asserted during the first FETCH cycle.
- **TRAP**: `trap` = 1, `fetch_valid` = 0, `dec_ready` = 0. Held until `rst_n` is asserted.
- Outside CALC, `adder_a` and `adder_b` are 0.
- **Simultaneous fetch acceptance and redirect acceptance**: the fetch handshake completes (memory returns the wrong-path word, which `redirect` flushes), but the redirect target wins the PC update.
- **Reset mid-CALC or in TRAP**: state returns to BOOT immediately, and `trap` and `trap_addr` clear.

## Timing
- **Handshake rule**: while `fetch_valid` = 1, `fetch_addr` stays stable until `fetch_ready`. The only exception is that an accepted redirect may drop `fetch_valid` on the next cycle (fetch abort).
- **Redirect latency**: descriptor accepted in cycle N; CALC in cycle N+1; in cycle N+2, `fetch_addr` = target with `fetch_valid` = 1 and `redirect` = 1.
- **Trap latency**: accepted in cycle N; `trap` = 1 from cycle N+2 onward.
- **Sequential fetch throughput**: one request per cycle while `fetch_ready` = 1.
- All outputs are registered, except `fetch_addr` (= `pc` register), `adder_a` and `adder_b` (from operand registers), and `dec_ready` (decoded from the state register).

## Test plan
- **Reset and sequential fetch**: RESET_PC = 0x100, `fetch_ready` held at 1 → first cycle after reset has `fetch_valid` = 0; then `fetch_addr` = 0x100, 0x104, 0x108 on consecutive cycles.
- **Backpressure**: `fetch_ready` = 0 for 3 cycles at 0x104 → `fetch_addr` holds 0x104 with `fetch_valid` = 1; it advances to 0x108 one cycle after `fetch_ready` rises.
- **Taken branch, then not-taken branch**:
  - Taken: `dec_pc` = 0x200, `br_imm` = 0xFFFF_FFF0 → `adder_a` = 0x200 and `adder_b` = 0xFFFF_FFF0 during CALC; `fetch_addr` = 0x1F0 with a one-cycle `redirect` at N+2.
  - Not taken: same descriptor with `br_taken` = 0 → no CALC and no redirect.
- **JALR**: `rs1_val` = 0x1001, `br_imm` = 0x3 → target = 0x1004 (bit 0 cleared), `redirect` asserted. Then `rs1_val` = 0x1000, `br_imm` = 0x2 → `trap` = 1, `trap_addr` = 0x1002, and fetch halts until reset.
- **Wrap-around and collision**:
  - PC = 0xFFFF_FFFC with `fetch_ready` → next PC = 0x0000_0000.
  - `fetch_ready` and a JAL accepted in the same cycle → PC becomes the JAL target, not PC+4.
- **Reset during CALC**: deassert `rst_n` in the CALC cycle → outputs clear immediately; PC = RESET_PC; no `redirect` pulse after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the RV32I fetch front end.
// Ports: clk/rst_n (async active-low reset); fetch_valid_o/fetch_addr_o/fetch_ready_i
// fetch handshake; dec_valid_i/dec_ready_o plus br_type_i, br_taken_i, br_imm_i,
// dec_pc_i, rs1_val_i control-flow descriptor; adder_a_o/adder_b_o/adder_sum_i shared
// external target adder; redirect_o flush pulse; trap_o/trap_addr_o misaligned-target trap.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ready_i,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [1:0]  br_type_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_imm_i,
    input  logic [31:0] dec_pc_i,
    input  logic [31:0] rs1_val_i,
    output logic [31:0] adder_a_o,
    output logic [31:0] adder_b_o,
    input  logic [31:0] adder_sum_i,
    output logic        redirect_o,
    output logic        trap_o,
    output logic [31:0] trap_addr_o
);
    typedef enum logic [1:0] {BOOT, FETCH, CALC, TRAP} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, opa_q, opb_q, trap_addr_q, target;
    logic        jalr_q, fetch_valid_q, redirect_q, trap_q, take, misaligned;
    // br_type 10/11 are jumps; 01 redirects only when taken
    assign take       = dec_valid_i && dec_ready_o && (br_type_i[1] || (br_type_i == 2'b01 && br_taken_i));
    assign target     = {adder_sum_i[31:1], adder_sum_i[0] & ~jalr_q};
    assign misaligned = |target[1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end
    always_comb begin
        state_d = state_q == BOOT  ? FETCH :
                  state_q == FETCH ? (take ? CALC : FETCH) :
                  state_q == CALC  ? (misaligned ? TRAP : FETCH) : TRAP;
    end
    always_comb begin
        dec_ready_o = state_q == FETCH;
        adder_a_o   = state_q == CALC ? opa_q : 32'h0;
        adder_b_o   = state_q == CALC ? opb_q : 32'h0;
    end
    // A redirect in CALC overrides any increment made while the descriptor was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            opa_q         <= 32'h0;
            opb_q         <= 32'h0;
            jalr_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            trap_q        <= 1'b0;
            trap_addr_q   <= 32'h0;
        end else begin
            if (state_q == CALC && !misaligned) begin
                pc_q <= target;
            end else if (fetch_valid_q && fetch_ready_i) begin
                pc_q <= pc_q + 32'd4;
            end
            if (take) begin
                opa_q  <= br_type_i == 2'b11 ? rs1_val_i : dec_pc_i;
                opb_q  <= br_imm_i;
                jalr_q <= br_type_i == 2'b11;
            end
            if (state_q == CALC && misaligned) begin
                trap_addr_q <= target;
            end
            fetch_valid_q <= state_d == FETCH;
            redirect_q    <= state_q == CALC && !misaligned;
            trap_q        <= state_d == TRAP;
        end
    end
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_addr_o  = pc_q;
    assign redirect_o    = redirect_q;
    assign trap_o        = trap_q;
    assign trap_addr_o   = trap_addr_q;
endmodule
